lfsr_sched: RTL
===============

Name: lfsr_sched

Overview:
- Shared pseudo-random source with round-robin scheduling: owns a WIDTH-bit Fibonacci LFSR and hands out one LFSR value per grant to NREQ requesters.
- Sequences the LFSR: seed load, enable/hold, lockup recovery and period tracking.
- The LFSR advances only on grants, so each requester receives a deterministic, non-repeating slice of the sequence.

Parameters:
- WIDTH, 4, LFSR width in bits (≥3).
- NREQ, 2, number of requesters (2..8).
- TAPS, 4'b1001, feedback tap mask; bit i set means state[i] feeds the XOR.
- SEED, 4'b0001, reset and lockup-recovery seed; must be nonzero.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  1 = grants allowed; 0 = requests held pending, LFSR frozen.
- seed_load  in  1  1-cycle strobe: load seed_in into LFSR.
- seed_in  in  WIDTH  seed value.
- req  in  NREQ  per-requester request, level; held until granted.
- gnt  out  NREQ  one-hot grant, registered, 1-cycle pulse.
- rnd_valid  out  1  high in the same cycle as any gnt bit.
- rnd_data  out  WIDTH  LFSR value for the granted requester.
- rnd_id  out  $clog2(NREQ)  index of the granted requester.
- step_cnt  out  WIDTH  grants since last seed load or reset, mod 2^WIDTH-1.
- period_done  out  1  1-cycle pulse when step_cnt wraps.
- lockup  out  1  sticky flag: an all-zero seed was attempted.
- gnt_cnt  out  NREQ*8  per-requester grant counters (see Optional Feature).

Behaviour:
- Reset (reset=0 at a clk edge): lfsr=SEED, gnt=0, rnd_valid=0, rnd_data=0, rnd_id=0, step_cnt=0, period_done=0, lockup=0, gnt_cnt=0. Round-robin pointer set so req[0] has top priority.
- LFSR step: fb = ^(lfsr & TAPS); next = {lfsr[WIDTH-2:0], fb}.
  - Defaults give a 15-state sequence: 0001,0011,0111,1111,1110,1101,1010,0101,1011,0110,1100,1001,0010,0100,1000, then repeat.
- Per-cycle priority, highest first: reset, seed_load, grant, hold.
- seed_load=1:
  - seed_in≠0: lfsr=seed_in and lockup cleared.
  - seed_in=0: lfsr=SEED and lockup=1.
  - In both cases step_cnt=0 and no grant that cycle. Pending reqs are served from the next cycle with the new seed.
- Grant: enable=1, seed_load=0, |req=1.
  - Round-robin winner is the first set req starting at (last_winner+1) mod NREQ.
  - Next edge: gnt[w]=1, rnd_valid=1, rnd_id=w, rnd_data = current lfsr (pre-advance). lfsr advances one step; pointer becomes w.
  - Latency is one cycle from a sampled req to gnt.
  - rnd_data and rnd_id hold their last values when rnd_valid=0.
- A requester drops req in the cycle it sees gnt. If req stays high it competes again at its new lowest priority.
- enable=0 or no req: gnt=0 and rnd_valid=0; lfsr, pointer and counters hold.
- step_cnt increments per grant. On the grant where it would reach 2^WIDTH-1 it becomes 0 and period_done pulses with that grant.
- Lockup guard: if lfsr is ever all-zero at a grant, rnd_data=SEED is issued, lfsr=next(SEED), lockup=1.
- Reset mid-operation overrides everything in the same cycle; any in-flight grant is lost.

Optional Feature:
- Macro: LFSR_SCHED_GNT_CNT_EN.
- Defined: gnt_cnt[8*i +: 8] is a saturating 8-bit count of grants to requester i. It stops at 255, is cleared by reset or seed_load, and updates on the same edge as gnt.
- Undefined: gnt_cnt tied to 0 and no counter flops synthesized.

Test Plan:
- Reset, enable=1, req=01 held for 5 cycles → gnt=01 each cycle from cycle 1; rnd_data = 0001,0011,0111,1111,1110; step_cnt 1..5.
- req=11 held, enable=1 → gnt alternates 01,10,01,10; rnd_id 0,1,0,1; rnd_data continues the single sequence with no repeats.
- 15 consecutive grants after reset → period_done pulses only on the 15th, step_cnt=0; the 16th rnd_data=0001.
- seed_load with seed_in=0000 while req=01 → no grant that cycle, lockup=1; next grant rnd_data=0001, then 0011.
- seed_load seed_in=1010, then enable=0 with req=10 for 3 cycles → no gnt. After enable=1 → gnt=10, rnd_data=1010, lockup cleared.
- With LFSR_SCHED_GNT_CNT_EN defined, 300 grants to req0 → gnt_cnt[7:0]=255, gnt_cnt[15:8]=0; reset mid-run → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/lfsr_sched.sv
// lfsr_sched: shared Fibonacci LFSR handed out one value per round-robin grant.
// Define LFSR_SCHED_GNT_CNT_EN to build saturating per-requester grant counters.
module lfsr_sched #(
  parameter int WIDTH = 4,
  parameter int NREQ = 2,
  parameter logic [WIDTH-1:0] TAPS = 4'b1001,
  parameter logic [WIDTH-1:0] SEED = 4'b0001
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     seed_load,
  input  logic [WIDTH-1:0]         seed_in,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          gnt,
  output logic                     rnd_valid,
  output logic [WIDTH-1:0]         rnd_data,
  output logic [$clog2(NREQ)-1:0]  rnd_id,
  output logic [WIDTH-1:0]         step_cnt,
  output logic                     period_done,
  output logic                     lockup,
  output logic [NREQ*8-1:0]        gnt_cnt
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [WIDTH-1:0] LAST = {{(WIDTH-1){1'b1}}, 1'b0};
  logic [WIDTH-1:0] lfsr, cur, nxt;
  logic [IDW-1:0] ptr, win;
  logic go, wrap;
  // An all-zero state would stick forever, so it is replaced by SEED at issue time.
  assign cur  = (lfsr == '0) ? SEED : lfsr;
  assign nxt  = {cur[WIDTH-2:0], ^(cur & TAPS)};
  assign go   = enable && |req;
  assign wrap = step_cnt == LAST;
  always_comb begin
    win = ptr;
    for (int k = NREQ; k >= 1; k--)
      if (req[(int'(ptr) + k) % NREQ]) win = IDW'((int'(ptr) + k) % NREQ);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr        <= SEED;
      ptr         <= IDW'(NREQ - 1);
      gnt         <= '0;
      rnd_valid   <= 1'b0;
      rnd_data    <= '0;
      rnd_id      <= '0;
      step_cnt    <= '0;
      period_done <= 1'b0;
      lockup      <= 1'b0;
    end else begin
      gnt         <= '0;
      rnd_valid   <= 1'b0;
      period_done <= 1'b0;
      if (seed_load) begin
        lfsr     <= (seed_in != '0) ? seed_in : SEED;
        lockup   <= seed_in == '0;
        step_cnt <= '0;
      end else if (go) begin
        gnt         <= NREQ'(1) << win;
        rnd_valid   <= 1'b1;
        rnd_id      <= win;
        rnd_data    <= cur;
        lfsr        <= nxt;
        ptr         <= win;
        step_cnt    <= wrap ? '0 : step_cnt + 1'b1;
        period_done <= wrap;
        if (lfsr == '0) lockup <= 1'b1;
      end
    end
  end
`ifdef LFSR_SCHED_GNT_CNT_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    logic [7:0] cnt;
    always_ff @(posedge clk) begin
      if (!reset || seed_load) cnt <= '0;
      else if (go && win == IDW'(g) && cnt != 8'hff) cnt <= cnt + 8'd1;
    end
    assign gnt_cnt[8*g +: 8] = cnt;
  end
`else
  assign gnt_cnt = '0;
`endif
endmodule
